// File: rtl/sd_dma_sched.sv
// rtl/sd_dma_sched.sv - splits one CPU job into DMA chunks; optional irq output under `SD_DMA_SCHED_IRQ_EN
module sd_dma_sched #(
  parameter int MAX_CHUNK     = 8,
  parameter int WORDS_PER_SEC = 128,
  parameter int TO_CYCLES     = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] job_sec,
  input  logic [31:0] job_cnt,
  input  logic [31:0] job_addr,
  input  logic        abort,
  input  logic        wr_beat,
  output logic [31:0] sec_addr,
  output logic [31:0] sec_counts,
  output logic [31:0] ahb_waddr,
  output logic        sd_read,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rem_cnt
`ifdef SD_DMA_SCHED_IRQ_EN
  ,
  input  logic        irq_clr,
  output logic        irq
`endif
);

  localparam logic [31:0] MAX_C    = 32'(MAX_CHUNK);
  localparam logic [31:0] WPS      = 32'(WORDS_PER_SEC);
  // The watchdog trips on the cycle whose increment would reach TO_CYCLES-1.
  localparam logic [31:0] WD_LIMIT = 32'(TO_CYCLES - 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;

  state_t      state, state_n;
  logic [31:0] cur_sec, cur_addr, rem;
  logic [31:0] chunk, exp_beats, beat_cnt, wd_cnt;
  logic        gap_cnt;

  logic [31:0] chunk_c, rem_after;
  logic        start_ok, beat_last, wd_expire, done_set, err_set;

  assign busy    = (state != S_IDLE);
  assign rem_cnt = rem;

  // Chunk sizing and the events that end a chunk or a job.
  always_comb begin
    chunk_c   = (rem > MAX_C) ? MAX_C : rem;
    rem_after = rem - chunk;
    start_ok  = (state == S_IDLE) && start && !abort;
    beat_last = (state == S_RUN) && wr_beat && (beat_cnt == exp_beats - 32'd1);
    wd_expire = (state == S_RUN) && !wr_beat && (wd_cnt == WD_LIMIT);
    done_set  = !abort && ((start_ok && (job_cnt == 32'd0)) ||
                           (beat_last && (rem_after == 32'd0)));
    err_set   = !abort && wd_expire;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start_ok && (job_cnt != 32'd0)) state_n = S_LOAD;
      S_LOAD: state_n = S_RUN;
      S_RUN: begin
        if (beat_last)      state_n = (rem_after == 32'd0) ? S_IDLE : S_GAP;
        else if (wd_expire) state_n = S_IDLE;
      end
      S_GAP:  if (gap_cnt) state_n = S_LOAD;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  // Job/chunk registers, beat and watchdog counters, status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sec    <= '0;
      cur_addr   <= '0;
      rem        <= '0;
      chunk      <= '0;
      exp_beats  <= '0;
      beat_cnt   <= '0;
      wd_cnt     <= '0;
      gap_cnt    <= 1'b0;
      sec_addr   <= '0;
      sec_counts <= '0;
      ahb_waddr  <= '0;
      sd_read    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      sd_read <= (state_n == S_RUN);
      done    <= done_set;
      if (err_set) err <= 1'b1;
      if (abort) begin
        rem <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              err <= 1'b0;
              if (job_cnt != 32'd0) begin
                cur_sec  <= job_sec;
                cur_addr <= job_addr;
                rem      <= job_cnt;
              end
            end
          end
          S_LOAD: begin
            sec_addr   <= cur_sec;
            sec_counts <= chunk_c;
            ahb_waddr  <= cur_addr;
            chunk      <= chunk_c;
            // A single-sector request is widened to two by the DMA.
            exp_beats  <= (chunk_c == 32'd1) ? (WPS << 1) : (chunk_c * WPS);
            beat_cnt   <= '0;
            wd_cnt     <= '0;
            gap_cnt    <= 1'b0;
          end
          S_RUN: begin
            if (wr_beat) begin
              beat_cnt <= beat_cnt + 32'd1;
              wd_cnt   <= '0;
            end else begin
              wd_cnt   <= wd_cnt + 32'd1;
            end
            if (beat_last) begin
              cur_sec  <= cur_sec + chunk;
              cur_addr <= cur_addr + (chunk << 9);
              rem      <= rem_after;
            end
          end
          S_GAP: gap_cnt <= 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef SD_DMA_SCHED_IRQ_EN
  // Sticky interrupt; a new set event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       irq <= 1'b0;
    else if (done_set || err_set)     irq <= 1'b1;
    else if (irq_clr)                 irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sd_dma_sched.sv
// tb/tb_sd_dma_sched.sv - scoreboard bench for sd_dma_sched with a chunk-list reference model
module tb_sd_dma_sched;

  localparam int MC  = 8;
  localparam int WPS = 128;
  localparam int TO  = 100;

  logic        clk, rst_n, start, abort, wr_beat;
  logic [31:0] job_sec, job_cnt, job_addr;
  logic [31:0] sec_addr, sec_counts, ahb_waddr, rem_cnt;
  logic        sd_read, busy, done, err;
`ifdef SD_DMA_SCHED_IRQ_EN
  logic        irq_clr, irq;
`endif

  sd_dma_sched #(.MAX_CHUNK(MC), .WORDS_PER_SEC(WPS), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .job_sec(job_sec), .job_cnt(job_cnt),
    .job_addr(job_addr), .abort(abort), .wr_beat(wr_beat), .sec_addr(sec_addr),
    .sec_counts(sec_counts), .ahb_waddr(ahb_waddr), .sd_read(sd_read), .busy(busy),
    .done(done), .err(err), .rem_cnt(rem_cnt)
`ifdef SD_DMA_SCHED_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  typedef struct {
    logic [31:0] sec;
    logic [31:0] cnt;
    logic [31:0] addr;
    bit          first;
  } chunk_t;

  typedef struct {
    bit is_err;
    bit zero;
  } end_t;

  chunk_t exp_chunk[$];
  end_t   exp_end[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_beat_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout cycle=%0d required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected records whenever the DUT presents a chunk, done or error.
  initial begin
    bit prev_sd = 0, prev_err = 0, prev_done = 0;
    int fall_cyc = 0;
    chunk_t c;
    end_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sd = 0; prev_err = 0; prev_done = 0;
        continue;
      end
      if (sd_read && !prev_sd) begin
        if (exp_chunk.size() == 0) begin
          chk("unexpected_sd_read_rise", 1, 0);
        end else begin
          c = exp_chunk.pop_front();
          chk("chunk_sec_addr", sec_addr, c.sec);
          chk("chunk_sec_counts", sec_counts, c.cnt);
          chk("chunk_ahb_waddr", ahb_waddr, c.addr);
          chk("chunk_busy", busy, 1);
          if (c.first) chk("start_to_sd_read_latency", cyc - start_cyc, 2);
          else         chk("sd_read_low_gap", cyc - fall_cyc, 3);
        end
      end
      if (!sd_read && prev_sd) fall_cyc = cyc;
      if (done) begin
        if (prev_done) begin
          chk("done_pulse_width", 2, 1);
        end else if (exp_end.size() == 0 || exp_end[0].is_err) begin
          chk("unexpected_done", 1, 0);
          if (exp_end.size() != 0) void'(exp_end.pop_front());
        end else begin
          e = exp_end.pop_front();
          chk("done_cycle", cyc, e.zero ? start_cyc + 1 : last_beat_cyc + 1);
          chk("done_busy", busy, 0);
          chk("done_rem_cnt", rem_cnt, 0);
        end
      end
      if (err && !prev_err) begin
        if (exp_end.size() == 0 || !exp_end[0].is_err) begin
          chk("unexpected_err", 1, 0);
          if (exp_end.size() != 0) void'(exp_end.pop_front());
        end else begin
          void'(exp_end.pop_front());
          chk("err_cycle", cyc, last_beat_cyc + TO);
          chk("err_sd_read", sd_read, 0);
          chk("err_busy", busy, 0);
        end
      end
      prev_sd = sd_read; prev_err = err; prev_done = done;
    end
  end

  // mode 0: normal, 1: beats stop after 10 in chunk 1, 2: abort halfway through chunk 2,
  // 3: stop driving after 20 beats of chunk 1 (for the reset test)
  task automatic run_job(input logic [31:0] s, input logic [31:0] c, input logic [31:0] a,
                         input int mode);
    chunk_t p[$];
    chunk_t e;
    end_t   r;
    logic [31:0] rs, ra, rr;
    int nb, b, n, last_k;
    rs = s; ra = a; rr = c;
    while (rr != 0) begin
      e.sec = rs;
      e.cnt = (rr > MC) ? MC : rr;
      e.addr = ra;
      e.first = (p.size() == 0);
      p.push_back(e);
      rs += e.cnt;
      ra += e.cnt * 512;
      rr -= e.cnt;
    end
    last_k = (mode == 1 || mode == 3) ? 0 : (mode == 2) ? 1 : p.size() - 1;
    for (int k = 0; k <= last_k; k++) exp_chunk.push_back(p[k]);
    r.zero = 0;
    if (mode == 0) begin r.is_err = 0; exp_end.push_back(r); end
    if (mode == 1) begin r.is_err = 1; exp_end.push_back(r); end

    start = 1; job_sec = s; job_cnt = c; job_addr = a; start_cyc = cyc;
    step();
    start = 0;
    for (int k = 0; k <= last_k; k++) begin
      n = 0;
      while (!sd_read && n < 64) begin
        wr_beat = ($urandom_range(0, 2) == 0);
        step();
        n++;
      end
      if (!sd_read) begin
        chk("sd_read_rise_timeout", 0, 1);
        wr_beat = 0;
        return;
      end
      nb = (p[k].cnt == 1) ? 2 * WPS : p[k].cnt * WPS;
      b = 0;
      while (b < nb) begin
        if (mode == 1 && b == 10) break;
        if (mode == 3 && b == 20) break;
        if (mode == 2 && k == 1 && b == nb / 2) break;
        wr_beat = ($urandom_range(0, 3) != 0);
        if (mode == 0 && k == 0 && b == 5) begin
          start = 1; job_cnt = $urandom_range(1, 50); job_sec = $urandom;
        end
        if (wr_beat) begin b++; last_beat_cyc = cyc; end
        step();
        wr_beat = 0; start = 0;
      end
      if (mode == 3) return;
      if (mode == 1) begin
        n = 0;
        while (busy && n < 300) begin step(); n++; end
        chk("wd_err_set", err, 1);
        chk("wd_sd_read_low", sd_read, 0);
        return;
      end
      if (mode == 2 && k == 1) begin
        abort = 1; wr_beat = 1;
        step();
        abort = 0; wr_beat = 0;
        chk("abort_busy", busy, 0);
        chk("abort_sd_read", sd_read, 0);
        chk("abort_rem_cnt", rem_cnt, 0);
        chk("abort_err_unchanged", err, 0);
        return;
      end
      chk("chunk_end_sd_read_low", sd_read, 0);
    end
    step();
    chk("job_end_busy", busy, 0);
  endtask

  task automatic zero_job();
    end_t r;
    r.is_err = 0; r.zero = 1;
    exp_end.push_back(r);
    start = 1; job_cnt = 0; job_sec = 32'h55; job_addr = 32'h100; start_cyc = cyc;
    step();
    start = 0;
    step(); step();
    chk("zero_job_err_cleared", err, 0);
    chk("zero_job_busy", busy, 0);
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; wr_beat = 0;
    job_sec = 0; job_cnt = 0; job_addr = 0;
`ifdef SD_DMA_SCHED_IRQ_EN
    irq_clr = 0;
`endif
    #12;
    chk("rst_sec_addr", sec_addr, 0);
    chk("rst_sec_counts", sec_counts, 0);
    chk("rst_ahb_waddr", ahb_waddr, 0);
    chk("rst_outputs", {28'd0, sd_read, busy, done, err}, 0);
    chk("rst_rem_cnt", rem_cnt, 0);
    step();
    rst_n = 1;
    step();

    run_job(32'h20, 3, 32'h1000_0000, 0);
    run_job(32'h20, 20, 32'h1000_0000, 0);
    run_job(32'h20, 17, 32'h1000_0000, 0);
    run_job(32'h40, 5, 32'h2000_0000, 1);
    step();
    abort = 1;
    step();
    abort = 0;
    chk("err_kept_on_idle_abort", err, 1);
    run_job(32'h80, 20, 32'h3000_0000, 2);
    run_job(32'h90, 2, 32'h3000_4000, 0);
    zero_job();
`ifdef SD_DMA_SCHED_IRQ_EN
    chk("irq_after_done", irq, 1);
    irq_clr = 1;
    step();
    irq_clr = 0;
    chk("irq_cleared", irq, 0);
`endif
    run_job(32'h1234, 9, 32'hFFFF_E000, 0);
    for (int j = 0; j < 5; j++)
      run_job($urandom, $urandom_range(1, 12), $urandom & 32'hFFFF_FFFC, 0);
    step(); step();
    chk("chunk_queue_empty", exp_chunk.size(), 0);
    chk("end_queue_empty", exp_end.size(), 0);

    run_job(32'h700, 10, 32'h4000_0000, 3);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_busy_sd_read", {busy, sd_read}, 0);
    chk("async_rst_rem_cnt", rem_cnt, 0);
    chk("async_rst_sec_counts", sec_counts, 0);
    step();
    rst_n = 1;
    step();
    chk("post_rst_chunk_queue_empty", exp_chunk.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
